// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : IF/D arbiter onto one shared req/ack memory port (IDLE/ISSUE/RESP).
//            Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT  = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int               c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner_d;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_be;
    logic [c_CNT_W-1:0]   r_tcnt;
    logic [31:0]          r_if_rdata;
    logic [31:0]          r_d_rdata;
    logic                 r_err;

    logic                 w_grant;
    logic                 w_grant_d;
    logic                 w_pick_d;
    logic                 w_issue;
    logic                 w_done;
    logic [31:0]          w_cap;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [15:0]          r_starve;

    // IF wins over a pending D only once D has been granted MAX_WAIT times in a row
    assign w_pick_d = d_req && !(if_req && (r_starve == 16'(MAX_WAIT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!if_req || (w_grant && !w_grant_d))
                r_starve <= '0;
            else if (w_grant_d)
                r_starve <= r_starve + 16'd1;
        end
    end
`else
    logic w_unused_max_wait;
    assign w_unused_max_wait = (MAX_WAIT != 0);
    assign w_pick_d          = d_req;
`endif

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_d) begin
                    w_grant   = 1'b1;
                    w_grant_d = 1'b1;
                    w_next    = ST_ISSUE;
                end else if (if_req) begin
                    w_grant = 1'b1;
                    w_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack || (r_tcnt == c_TMO_LAST))
                    w_next = ST_RESP;
            end
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_done = (r_state == ST_ISSUE) && (w_next == ST_RESP);
    // Stores and timeouts both return zero data
    assign w_cap  = (mem_ack && !r_we) ? mem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner_d  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_tcnt     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner_d <= w_grant_d;
                r_addr    <= w_grant_d ? d_addr : if_addr;
                r_we      <= w_grant_d & d_we;
                r_wdata   <= w_grant_d ? d_wdata : 32'd0;
                r_be      <= w_grant_d ? d_be : 4'd0;
            end
            if ((r_state == ST_ISSUE) && (w_next == ST_ISSUE))
                r_tcnt <= r_tcnt + 1'b1;
            else
                r_tcnt <= '0;
            if (w_done) begin
                if (r_owner_d)
                    r_d_rdata <= w_cap;
                else
                    r_if_rdata <= w_cap;
                if (!mem_ack)
                    r_err <= 1'b1;
            end
        end
    end

    assign w_issue   = (r_state == ST_ISSUE);
    assign busy      = (r_state != ST_IDLE);
    assign mem_req   = w_issue;
    assign mem_we    = w_issue & r_we;
    assign mem_addr  = w_issue ? r_addr  : 32'd0;
    assign mem_wdata = w_issue ? r_wdata : 32'd0;
    assign mem_be    = w_issue ? r_be    : 4'd0;
    assign if_ready  = (r_state == ST_RESP) && !r_owner_d;
    assign d_ready   = (r_state == ST_RESP) &&  r_owner_d;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter: directed scenarios with literal
//            expectations plus randomized traffic against an access-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int TIMEOUT  = 8;
    localparam int MAX_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, busy, err;
    logic [3:0]  mem_be;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Access-level model: one outstanding access record plus a response flag
    bit          m_act, m_resp, m_own_d, m_we, m_err;
    int          m_wait, m_starve;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    logic [3:0]  m_be;

    // Output samples taken mid-cycle
    logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
    logic        s_if_ready, s_d_ready, s_mem_req, s_mem_we, s_busy, s_err;
    logic [3:0]  s_mem_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_update();
        bit gd, gi, force_if;
        logic [31:0] cap;
        if (rst) begin
            m_act = 0; m_resp = 0; m_own_d = 0; m_we = 0; m_err = 0;
            m_wait = 0; m_starve = 0; m_addr = 0; m_wdata = 0; m_be = 0;
            m_ifr = 0; m_dr = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_act) begin
            if (mem_ack || m_wait == TIMEOUT - 1) begin
                cap = (mem_ack && !m_we) ? mem_rdata : 32'd0;
                if (!mem_ack) m_err = 1;
                if (m_own_d) m_dr = cap; else m_ifr = cap;
                m_act  = 0;
                m_resp = 1;
            end else begin
                m_wait++;
            end
        end else begin
            gd = 0; gi = 0; force_if = 0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            force_if = if_req && (m_starve == MAX_WAIT);
`endif
            if (d_req && !force_if) gd = 1;
            else if (if_req)        gi = 1;
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (!if_req || gi) m_starve = 0;
            else if (gd)       m_starve++;
`endif
            if (gd || gi) begin
                m_act   = 1;
                m_wait  = 0;
                m_own_d = gd;
                m_addr  = gd ? d_addr : if_addr;
                m_we    = gd && d_we;
                m_wdata = gd ? d_wdata : 32'd0;
                m_be    = gd ? d_be : 4'd0;
            end
        end
    endfunction

    // One clock: sample and compare at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge clk);
        s_if_rdata = if_rdata;  s_d_rdata = d_rdata;  s_mem_addr = mem_addr;
        s_mem_wdata = mem_wdata; s_if_ready = if_ready; s_d_ready = d_ready;
        s_mem_req = mem_req; s_mem_we = mem_we; s_busy = busy; s_err = err; s_mem_be = mem_be;
        chk("mem_req",  s_mem_req,  m_act);
        chk("if_ready", s_if_ready, m_resp && !m_own_d);
        chk("d_ready",  s_d_ready,  m_resp && m_own_d);
        chk("if_rdata", s_if_rdata, m_ifr);
        chk("d_rdata",  s_d_rdata,  m_dr);
        chk("busy",     s_busy,     m_act || m_resp);
        chk("err",      s_err,      m_err);
        if (m_act) begin
            chk("mem_addr",  s_mem_addr,  m_addr);
            chk("mem_we",    s_mem_we,    m_we);
            chk("mem_wdata", s_mem_wdata, m_wdata);
            chk("mem_be",    s_mem_be,    m_be);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    endtask

    int          cnt, ngr, nifr;
    logic [31:0] grants [6];
    logic [31:0] exp_gr [6];
    bit          dead;

    initial begin
        rst = 1; quiet();
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        @(posedge clk); #1;
        model_update();
        step();
        chk("reset mem_req", s_mem_req, 0);
        chk("reset busy",    s_busy, 0);
        chk("reset err",     s_err, 0);
        chk("reset if_rdata", s_if_rdata, 0);
        rst = 0;
        step();

        // Single fetch
        if_req = 1; if_addr = 32'h10; step();
        mem_ack = 1; mem_rdata = 32'h0050_0093; step();
        chk("fetch mem_req", s_mem_req, 1);
        chk("fetch mem_addr", s_mem_addr, 32'h10);
        chk("fetch mem_we", s_mem_we, 0);
        mem_ack = 0; mem_rdata = 32'h1234_5678; step();
        chk("fetch if_ready", s_if_ready, 1);
        chk("fetch if_rdata", s_if_rdata, 32'h0050_0093);
        if_req = 0; step();
        chk("fetch busy idle", s_busy, 0);

        // Contention: D first, then IF
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF; step();
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D; step();
        chk("cont D addr", s_mem_addr, 32'h200);
        mem_ack = 0; step();
        chk("cont d_ready", s_d_ready, 1);
        chk("cont d_rdata", s_d_rdata, 32'hCAFE_F00D);
        d_req = 0; step();
        mem_ack = 1; mem_rdata = 32'h13; step();
        chk("cont IF addr", s_mem_addr, 32'h44);
        mem_ack = 0; step();
        chk("cont if_ready", s_if_ready, 1);
        if_req = 0; step();

        // Store with three wait states; inputs wiggle after grant
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; step();
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3); mem_rdata = $urandom;
            d_addr = $urandom; d_wdata = $urandom; d_be = 4'h3; d_we = 0;
            step();
            cnt += int'(s_mem_req);
            chk("store addr", s_mem_addr, 32'h100);
            chk("store wdata", s_mem_wdata, 32'hDEAD_BEEF);
            chk("store be", s_mem_be, 4'hF);
            chk("store we", s_mem_we, 1);
        end
        mem_ack = 0; step();
        chk("store req cycles", cnt, 4);
        chk("store d_ready", s_d_ready, 1);
        chk("store d_rdata", s_d_rdata, 0);
        d_req = 0; step();

        // Timeout on a fetch
        if_req = 1; if_addr = 32'h80; step();
        cnt = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            step();
            cnt += int'(s_mem_req);
        end
        chk("tmo req cycles", cnt, TIMEOUT);
        step();
        chk("tmo if_ready", s_if_ready, 1);
        chk("tmo if_rdata", s_if_rdata, 0);
        chk("tmo err", s_err, 1);
        if_req = 0; step();
        if_req = 1; if_addr = 32'h84; step();
        mem_ack = 1; mem_rdata = 32'h77; step();
        mem_ack = 0; if_req = 0; step(); step();
        chk("err sticky", s_err, 1);

        // Reset during the second ISSUE cycle
        d_req = 1; d_we = 0; d_addr = 32'h300; step();
        step();
        rst = 1; step();
        chk("rst issue2 req", s_mem_req, 1);
        rst = 0; d_req = 0; step();
        chk("rst mem_req", s_mem_req, 0);
        chk("rst busy", s_busy, 0);
        chk("rst err", s_err, 0);
        chk("rst d_ready", s_d_ready, 0);
        chk("rst if_rdata", s_if_rdata, 0);
        chk("rst d_rdata", s_d_rdata, 0);
        step();
        chk("rst no ready", s_d_ready | s_if_ready, 0);

        // Both requesters held continuously
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_gr = '{32'h300, 32'h300, 32'h400, 32'h300, 32'h300, 32'h400};
`else
        exp_gr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h300, 32'h300};
`endif
        d_req = 1; d_we = 0; d_addr = 32'h300; if_req = 1; if_addr = 32'h400;
        ngr = 0; nifr = 0;
        for (int k = 0; k < 40 && ngr < 6; k++) begin
            mem_ack = mem_req; mem_rdata = $urandom;
            step();
            nifr += int'(s_if_ready);
            if (s_mem_req) begin
                grants[ngr] = s_mem_addr;
                ngr++;
            end
        end
        chk("starve grant count", ngr, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("starve grant %0d", k), grants[k], exp_gr[k]);
`ifndef MEM_ARB_STARVE_GUARD_EN
        chk("starve no if_ready", nifr, 0);
`endif
        quiet(); step(); step(); step();

        // Randomized traffic
        dead = 0;
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom % 400 == 0);
            if (!if_req) if_req = ($urandom % 3 == 0);
            else if (s_if_ready) if_req = $urandom % 2;
            if (!d_req) d_req = ($urandom % 3 == 0);
            else if (s_d_ready) d_req = $urandom % 2;
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_be = 4'($urandom); d_we = $urandom % 2; mem_rdata = $urandom;
            if (!mem_req) dead = ($urandom % 20 == 0);
            mem_ack = mem_req ? (!dead && ($urandom % 3 == 0)) : ($urandom % 2 == 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
